// File: rtl/anubis_pkg.sv
// Shared constants, state encoding and helpers for the Anubis-128 round-key store.
package anubis_pkg;

    localparam int NUM_ROUND_KEYS = 13;
    localparam int KEY_W          = 128;
    localparam int MAX_ROUND_IDX  = 12;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_ZEROIZE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_COLLECT = ST_COLLECT,
        S_READY   = ST_READY,
        S_ZEROIZE = ST_ZEROIZE
    } state_t;

    function automatic logic [3:0] popcount13(input logic [NUM_ROUND_KEYS-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/key_reg_file.sv
// Round-key storage: one-hot per-slot synchronous write, registered read with synchronous clear.
module key_reg_file #(
    parameter int NUM_KEYS = 13,
    parameter int KEY_W    = 128
) (
    input  logic                clk,
    input  logic [NUM_KEYS-1:0] wr_sel,
    input  logic [KEY_W-1:0]    wr_data,
    input  logic                rd_en,
    input  logic                rd_clr,
    input  logic [3:0]          rd_addr,
    output logic [KEY_W-1:0]    rd_data
);

    logic [KEY_W-1:0] mem [NUM_KEYS];

    // Slot writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Read register: clear dominates, otherwise hold between reads.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/round_key_store.sv
// Round-key buffer between key schedule and round datapath, with reversible read order.
// Optional zeroize sweep on reset/abort enabled by defining KEY_STORE_ZEROIZE_EN.
module round_key_store #(
    parameter int NUM_KEYS = 13,
    parameter int KEY_W    = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             encrypt,
    input  logic [KEY_W-1:0] round_key_in,
    input  logic [3:0]       key_number_in,
    input  logic             rd_req,
    input  logic [3:0]       rd_index,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_valid,
    output logic             rd_err,
    output logic             keys_ready,
    output logic [3:0]       key_count,
    output logic             busy
);

    import anubis_pkg::*;

`ifdef KEY_STORE_ZEROIZE_EN
    localparam state_t RESET_STATE = S_ZEROIZE;
    localparam state_t ABORT_STATE = S_ZEROIZE;
    logic [3:0] zero_idx_r;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam state_t ABORT_STATE = S_IDLE;
`endif

    state_t               state_r;
    state_t               state_nx;
    logic [NUM_KEYS-1:0]  valid_r;
    logic [NUM_KEYS-1:0]  valid_nx;
    logic [3:0]           last_num_r;
    logic [3:0]           key_count_r;
    logic                 dir_r;
    logic                 load_prev_r;
    logic                 rd_valid_r;
    logic                 rd_err_r;

    logic                 load_rise;
    logic                 capture;
    logic [3:0]           cap_slot;
    logic [NUM_KEYS-1:0]  wr_sel;
    logic [KEY_W-1:0]     wr_data;
    logic                 rd_en;
    logic                 rd_clr;
    logic [3:0]           rd_addr;
    logic                 rd_valid_nx;
    logic                 rd_err_nx;

    assign load_rise = load & ~load_prev_r;
    assign capture   = (key_number_in != last_num_r) &&
                       (key_number_in >= 4'd1) && (key_number_in <= 4'(NUM_KEYS));
    assign cap_slot  = key_number_in - 4'd1;

    // Next-state, slot write and read-port control.
    always_comb begin
        state_nx    = state_r;
        valid_nx    = valid_r;
        wr_sel      = '0;
        wr_data     = round_key_in;
        rd_en       = 1'b0;
        rd_addr     = 4'd0;
        rd_valid_nx = 1'b0;
        rd_err_nx   = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (load_rise) begin
                    state_nx = S_COLLECT;
                    valid_nx = '0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (!load) begin
                    state_nx = ABORT_STATE;
                    valid_nx = '0;
                end else if (&valid_r) begin
                    state_nx = S_READY;
                end else if (capture) begin
                    wr_sel   = {{(NUM_KEYS-1){1'b0}}, 1'b1} << cap_slot;
                    valid_nx = valid_r | wr_sel;
                end else begin
                    state_nx = S_COLLECT;
                end
            end
            S_READY: begin
                if (load_rise) begin
                    state_nx = S_COLLECT;
                    valid_nx = '0;
                end else begin
                    state_nx = S_READY;
                end
            end
`ifdef KEY_STORE_ZEROIZE_EN
            S_ZEROIZE: begin
                wr_sel  = {{(NUM_KEYS-1){1'b0}}, 1'b1} << zero_idx_r;
                wr_data = '0;
                if (zero_idx_r == 4'(MAX_ROUND_IDX)) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_ZEROIZE;
                end
            end
`endif
            default: begin
                state_nx = RESET_STATE;
                valid_nx = '0;
            end
        endcase

        // A re-entry load edge pre-empts a read issued in the same cycle.
        if (rd_req) begin
            if ((state_r == S_READY) && !load_rise && (rd_index <= 4'(MAX_ROUND_IDX))) begin
                rd_en       = 1'b1;
                rd_valid_nx = 1'b1;
                rd_addr     = dir_r ? rd_index : (4'(MAX_ROUND_IDX) - rd_index);
            end else begin
                rd_err_nx = 1'b1;
            end
        end else begin
            rd_err_nx = 1'b0;
        end

        if (reset) begin
            wr_sel = '0;
            rd_en  = 1'b0;
        end else begin
            rd_en = rd_en;
        end

        rd_clr = reset | rd_err_nx;
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RESET_STATE;
            valid_r     <= '0;
            last_num_r  <= 4'd0;
            key_count_r <= 4'd0;
            dir_r       <= 1'b0;
            load_prev_r <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_err_r    <= 1'b0;
        end else begin
            state_r     <= state_nx;
            valid_r     <= valid_nx;
            key_count_r <= popcount13(valid_nx);
            last_num_r  <= key_number_in;
            load_prev_r <= load;
            rd_valid_r  <= rd_valid_nx;
            rd_err_r    <= rd_err_nx;
            if ((state_nx == S_COLLECT) && (state_r != S_COLLECT)) begin
                dir_r <= encrypt;
            end
        end
    end

`ifdef KEY_STORE_ZEROIZE_EN
    // Sweep pointer, restarted on every entry into the zeroize state.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_idx_r <= 4'd0;
        end else if ((state_nx == S_ZEROIZE) && (state_r != S_ZEROIZE)) begin
            zero_idx_r <= 4'd0;
        end else if (state_r == S_ZEROIZE) begin
            zero_idx_r <= zero_idx_r + 4'd1;
        end
    end

    assign busy = (state_r == S_ZEROIZE);
`else
    assign busy = 1'b0;
`endif

    assign keys_ready = (state_r == S_READY);
    assign key_count  = key_count_r;
    assign rd_valid   = rd_valid_r;
    assign rd_err     = rd_err_r;

    key_reg_file #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W)
    ) u_key_reg_file (
        .clk     (clk),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_addr (rd_addr),
        .rd_data (rd_key)
    );

endmodule

// File: tb/tb_round_key_store.sv
// Directed, table-driven bench for round_key_store; zeroize checks run when KEY_STORE_ZEROIZE_EN is defined.
module tb_round_key_store;

    logic         clk;
    logic         reset;
    logic         load;
    logic         encrypt;
    logic [127:0] round_key_in;
    logic [3:0]   key_number_in;
    logic         rd_req;
    logic [3:0]   rd_index;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;
    logic         keys_ready;
    logic [3:0]   key_count;
    logic         busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0]   idx;
        logic         exp_valid;
        logic         exp_err;
        logic [127:0] exp_key;
    } rd_vec_t;

    rd_vec_t enc_tab [5];
    rd_vec_t dec_tab [4];

    round_key_store dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .encrypt       (encrypt),
        .round_key_in  (round_key_in),
        .key_number_in (key_number_in),
        .rd_req        (rd_req),
        .rd_index      (rd_index),
        .rd_key        (rd_key),
        .rd_valid      (rd_valid),
        .rd_err        (rd_err),
        .keys_ready    (keys_ready),
        .key_count     (key_count),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] key_of(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {16{b}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 40 && busy; i++) begin
            tick();
        end
        chk("busy_timeout", {127'd0, busy}, 128'd0);
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_req   = 1'b1;
        rd_index = idx;
        tick();
        rd_req   = 1'b0;
    endtask

    task automatic collect(input logic enc);
        load          = 1'b0;
        key_number_in = 4'd0;
        tick();
        load    = 1'b1;
        encrypt = enc;
        tick();
        for (int n = 1; n <= 13; n++) begin
            key_number_in = 4'(n);
            round_key_in  = key_of(n - 1);
            tick();
            if (n == 13) begin
                chk("count_13", {124'd0, key_count}, 128'd13);
                chk("ready_not_yet", {127'd0, keys_ready}, 128'd0);
            end
        end
        tick();
        chk("keys_ready", {127'd0, keys_ready}, 128'd1);
    endtask

    initial begin
        enc_tab[0] = '{idx: 4'd0,  exp_valid: 1'b1, exp_err: 1'b0, exp_key: key_of(0)};
        enc_tab[1] = '{idx: 4'd12, exp_valid: 1'b1, exp_err: 1'b0, exp_key: key_of(12)};
        enc_tab[2] = '{idx: 4'd13, exp_valid: 1'b0, exp_err: 1'b1, exp_key: 128'd0};
        enc_tab[3] = '{idx: 4'd15, exp_valid: 1'b0, exp_err: 1'b1, exp_key: 128'd0};
        enc_tab[4] = '{idx: 4'd5,  exp_valid: 1'b1, exp_err: 1'b0, exp_key: key_of(5)};
        dec_tab[0] = '{idx: 4'd0,  exp_valid: 1'b1, exp_err: 1'b0, exp_key: key_of(12)};
        dec_tab[1] = '{idx: 4'd12, exp_valid: 1'b1, exp_err: 1'b0, exp_key: key_of(0)};
        dec_tab[2] = '{idx: 4'd13, exp_valid: 1'b0, exp_err: 1'b1, exp_key: 128'd0};
        dec_tab[3] = '{idx: 4'd7,  exp_valid: 1'b1, exp_err: 1'b0, exp_key: key_of(5)};

        reset         = 1'b1;
        load          = 1'b0;
        encrypt       = 1'b0;
        round_key_in  = 128'd0;
        key_number_in = 4'd0;
        rd_req        = 1'b0;
        rd_index      = 4'd0;
        tick();
        chk("rst_keys_ready", {127'd0, keys_ready}, 128'd0);
        chk("rst_key_count", {124'd0, key_count}, 128'd0);
        chk("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
        chk("rst_rd_err", {127'd0, rd_err}, 128'd0);
        chk("rst_rd_key", rd_key, 128'd0);
`ifdef KEY_STORE_ZEROIZE_EN
        chk("rst_busy", {127'd0, busy}, 128'd1);
`else
        chk("rst_busy", {127'd0, busy}, 128'd0);
`endif
        reset = 1'b0;
        wait_not_busy();

        // Read before any collection.
        do_read(4'd0);
        chk("idle_rd_err", {127'd0, rd_err}, 128'd1);
        chk("idle_rd_valid", {127'd0, rd_valid}, 128'd0);
        chk("idle_rd_key", rd_key, 128'd0);

        collect(1'b1);
        for (int i = 0; i < 5; i++) begin
            do_read(enc_tab[i].idx);
            chk("enc_valid", {127'd0, rd_valid}, {127'd0, enc_tab[i].exp_valid});
            chk("enc_err", {127'd0, rd_err}, {127'd0, enc_tab[i].exp_err});
            chk("enc_key", rd_key, enc_tab[i].exp_key);
        end
        tick();
        chk("hold_valid", {127'd0, rd_valid}, 128'd0);
        chk("hold_key", rd_key, key_of(5));

        // READY persists after load falls.
        load = 1'b0;
        tick();
        tick();
        chk("ready_after_load_fall", {127'd0, keys_ready}, 128'd1);

        collect(1'b0);
        for (int i = 0; i < 4; i++) begin
            do_read(dec_tab[i].idx);
            chk("dec_valid", {127'd0, rd_valid}, {127'd0, dec_tab[i].exp_valid});
            chk("dec_err", {127'd0, rd_err}, {127'd0, dec_tab[i].exp_err});
            chk("dec_key", rd_key, dec_tab[i].exp_key);
        end

        // Re-entry load edge together with a read: the load edge wins.
        load = 1'b0;
        tick();
        load     = 1'b1;
        rd_req   = 1'b1;
        rd_index = 4'd3;
        tick();
        rd_req = 1'b0;
        chk("reentry_rd_err", {127'd0, rd_err}, 128'd1);
        chk("reentry_rd_valid", {127'd0, rd_valid}, 128'd0);
        chk("reentry_ready_drop", {127'd0, keys_ready}, 128'd0);

        // Duplicates and abort.
        load          = 1'b0;
        key_number_in = 4'd0;
        tick();
        load    = 1'b1;
        encrypt = 1'b1;
        tick();
        chk("entry_count", {124'd0, key_count}, 128'd0);
        for (int n = 1; n <= 3; n++) begin
            key_number_in = 4'(n);
            round_key_in  = key_of(n + 32);
            tick();
        end
        key_number_in = 4'd4;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("dup_count", {124'd0, key_count}, 128'd4);
        key_number_in = 4'd0;
        tick();
        key_number_in = 4'd15;
        tick();
        chk("out_of_range_count", {124'd0, key_count}, 128'd4);
        for (int n = 5; n <= 6; n++) begin
            key_number_in = 4'(n);
            tick();
        end
        chk("six_count", {124'd0, key_count}, 128'd6);
        load = 1'b0;
        tick();
        chk("abort_ready", {127'd0, keys_ready}, 128'd0);
        chk("abort_count", {124'd0, key_count}, 128'd0);
        do_read(4'd2);
        chk("abort_rd_err", {127'd0, rd_err}, 128'd1);
        chk("abort_rd_valid", {127'd0, rd_valid}, 128'd0);
        wait_not_busy();

        // Reset while READY.
        collect(1'b1);
        do_read(4'd9);
        chk("pre_reset_key", rd_key, key_of(9));
        reset = 1'b1;
        load  = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_ready_keys_ready", {127'd0, keys_ready}, 128'd0);
        chk("rst_ready_count", {124'd0, key_count}, 128'd0);
        chk("rst_ready_rd_key", rd_key, 128'd0);
        wait_not_busy();

`ifdef KEY_STORE_ZEROIZE_EN
        begin
            int busy_cycles;
            busy_cycles   = 0;
            key_number_in = 4'd0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (busy) begin
                    busy_cycles++;
                end
                if (i == 3) begin
                    load = 1'b1;
                end
                if (i == 20) begin
                    key_number_in = 4'd1;
                end
                tick();
            end
            chk("zeroize_cycles", 128'(busy_cycles), 128'd13);
            chk("zeroize_load_ignored", {124'd0, key_count}, 128'd0);
            chk("zeroize_no_ready", {127'd0, keys_ready}, 128'd0);
            load = 1'b0;
            tick();
            load = 1'b1;
            tick();
            chk("post_zeroize_entry", {124'd0, key_count}, 128'd0);
            key_number_in = 4'd2;
            tick();
            chk("post_zeroize_capture", {124'd0, key_count}, 128'd1);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
